// File: rtl/key_pulse_conditioner_pkg.sv
// Shared definitions for the key pulse conditioner: key indices and per-key debounce FSM states.
package key_pulse_conditioner_pkg;

    localparam int NUM_KEYS    = 5;
    localparam int KEY_RESTART = 0;
    localparam int KEY_LEFT    = 1;
    localparam int KEY_RIGHT   = 2;
    localparam int KEY_UP      = 3;
    localparam int KEY_DOWN    = 4;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

endpackage

// File: rtl/key_debounce_fsm.sv
// One key: 2-flop synchroniser, stability counter and debounce FSM.
// held_o is registered; press_evt_o is the combinational "entering HELD" strobe.
module key_debounce_fsm
    import key_pulse_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic key_i,
    output logic held_o,
    output logic press_evt_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic                 sync1_q;
    logic                 sync2_q;
    key_state_t           state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 held_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            held_q  <= 1'b0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
            case (state_q)
                IDLE: begin
                    if (sync2_q) begin
                        state_q <= PRESS_WAIT;
                        cnt_q   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync2_q) begin
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= HELD;
                        held_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!sync2_q) begin
                        state_q <= RELEASE_WAIT;
                        cnt_q   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    // Bounce back to HELD without a new event.
                    if (sync2_q) begin
                        state_q <= HELD;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE;
                        held_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign held_o      = held_q;
    assign press_evt_o = (state_q == PRESS_WAIT) && sync2_q && (cnt_q == CNT_LAST);

endmodule

// File: rtl/key_pulse_conditioner.sv
// Five debounced push-buttons to one-cycle registered press pulses.
// Direction pulses are mutually exclusive (Left > Right > Up > Down); restart is independent.
module key_pulse_conditioner
    import key_pulse_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_WIDTH       = 20,
    parameter int KEY_ACTIVE_LOW  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic                RESTARTdown,
    output logic                LeftDown,
    output logic                RightDown,
    output logic                UpDown,
    output logic                DownDown,
    output logic [NUM_KEYS-1:0] key_held
);

    logic [NUM_KEYS-1:0] key_norm;
    logic [NUM_KEYS-1:0] press_evt;
    logic [NUM_KEYS-1:0] held;
    logic [NUM_KEYS-1:0] pulse_d;
    logic [NUM_KEYS-1:0] pulse_q;

    assign key_norm = (KEY_ACTIVE_LOW != 0) ? ~key_raw : key_raw;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce_fsm #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_WIDTH      (CNT_WIDTH)
        ) u_fsm (
            .clk        (clk),
            .rst        (rst),
            .key_i      (key_norm[i]),
            .held_o     (held[i]),
            .press_evt_o(press_evt[i])
        );
    end

    // Losing direction events are dropped, never deferred.
    always_comb begin
        pulse_d              = '0;
        pulse_d[KEY_RESTART] = press_evt[KEY_RESTART];
        pulse_d[KEY_LEFT]    = press_evt[KEY_LEFT];
        pulse_d[KEY_RIGHT]   = press_evt[KEY_RIGHT] && !press_evt[KEY_LEFT];
        pulse_d[KEY_UP]      = press_evt[KEY_UP] && !press_evt[KEY_LEFT] && !press_evt[KEY_RIGHT];
        pulse_d[KEY_DOWN]    = press_evt[KEY_DOWN] && !press_evt[KEY_LEFT] && !press_evt[KEY_RIGHT]
                               && !press_evt[KEY_UP];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_q <= '0;
        end else begin
            pulse_q <= pulse_d;
        end
    end

    assign RESTARTdown = pulse_q[KEY_RESTART];
    assign LeftDown    = pulse_q[KEY_LEFT];
    assign RightDown   = pulse_q[KEY_RIGHT];
    assign UpDown      = pulse_q[KEY_UP];
    assign DownDown    = pulse_q[KEY_DOWN];
    assign key_held    = held;

endmodule

// File: tb/tb_key_pulse_conditioner.sv
// Directed bench for key_pulse_conditioner with DEBOUNCE_CYCLES=8, active-low keys.
module tb_key_pulse_conditioner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] key_raw = 5'h1F;
    logic       RESTARTdown, LeftDown, RightDown, UpDown, DownDown;
    logic [4:0] key_held;

    int checks = 0;
    int errors = 0;

    int rs_cnt = 0, l_cnt = 0, r_cnt = 0, u_cnt = 0, d_cnt = 0;
    int right_held_seen = 0;
    int up_drop = 0;
    bit watch_up = 1'b0;

    key_pulse_conditioner #(
        .DEBOUNCE_CYCLES(8),
        .CNT_WIDTH      (4),
        .KEY_ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_raw    (key_raw),
        .RESTARTdown(RESTARTdown),
        .LeftDown   (LeftDown),
        .RightDown  (RightDown),
        .UpDown     (UpDown),
        .DownDown   (DownDown),
        .key_held   (key_held)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (RESTARTdown) rs_cnt++;
        if (LeftDown)    l_cnt++;
        if (RightDown)   r_cnt++;
        if (UpDown)      u_cnt++;
        if (DownDown)    d_cnt++;
        if (key_held[2]) right_held_seen++;
        if (watch_up && !key_held[3]) up_drop++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_counts();
        rs_cnt = 0; l_cnt = 0; r_cnt = 0; u_cnt = 0; d_cnt = 0;
        right_held_seen = 0; up_drop = 0;
    endtask

    function automatic logic [4:0] pulses();
        return {DownDown, UpDown, RightDown, LeftDown, RESTARTdown};
    endfunction

    initial begin
        step(3);
        chk("reset_pulses", 32'(pulses()), 32'h0);
        chk("reset_held", 32'(key_held), 32'h0);
        rst = 1'b0;
        step(3);
        chk("idle_pulses", 32'(pulses()), 32'h0);

        // 1: left press, pulse after edge 10, no auto-repeat
        clear_counts();
        key_raw[1] = 1'b0;
        step(10);
        chk("t1_left_early", 32'(LeftDown), 32'h0);
        chk("t1_held_early", 32'(key_held[1]), 32'h0);
        step(1);
        chk("t1_left_pulse", 32'(LeftDown), 32'h1);
        chk("t1_held_rise", 32'(key_held[1]), 32'h1);
        step(1);
        chk("t1_left_one_cycle", 32'(LeftDown), 32'h0);
        step(100);
        chk("t1_left_count", 32'(l_cnt), 32'd1);
        chk("t1_held_kept", 32'(key_held[1]), 32'h1);
        key_raw[1] = 1'b1;
        step(20);
        chk("t1_released", 32'(key_held[1]), 32'h0);

        // 2: right bouncing every 3 cycles never qualifies
        clear_counts();
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) key_raw[2] = ~key_raw[2];
            step(1);
        end
        key_raw[2] = 1'b1;
        step(20);
        chk("t2_right_count", 32'(r_cnt), 32'd0);
        chk("t2_right_held", 32'(right_held_seen), 32'd0);

        // 3: short release glitch on up does not re-pulse nor drop held
        clear_counts();
        key_raw[3] = 1'b0;
        step(12);
        chk("t3_up_held", 32'(key_held[3]), 32'h1);
        watch_up = 1'b1;
        key_raw[3] = 1'b1;
        step(4);
        key_raw[3] = 1'b0;
        step(20);
        watch_up = 1'b0;
        chk("t3_up_count", 32'(u_cnt), 32'd1);
        chk("t3_up_no_drop", 32'(up_drop), 32'd0);
        key_raw[3] = 1'b1;
        step(20);

        // 4: left and down together, left wins, down discarded
        clear_counts();
        key_raw[1] = 1'b0;
        key_raw[4] = 1'b0;
        step(11);
        chk("t4_pulses", 32'(pulses()), 32'h02);
        step(30);
        chk("t4_left_count", 32'(l_cnt), 32'd1);
        chk("t4_down_count", 32'(d_cnt), 32'd0);
        chk("t4_held", 32'(key_held), 32'h12);
        key_raw[1] = 1'b1;
        key_raw[4] = 1'b1;
        step(20);

        // 5: restart and right pulse in the same cycle
        clear_counts();
        key_raw[0] = 1'b0;
        key_raw[2] = 1'b0;
        step(11);
        chk("t5_pulses", 32'(pulses()), 32'h05);
        step(20);
        chk("t5_restart_count", 32'(rs_cnt), 32'd1);
        chk("t5_right_count", 32'(r_cnt), 32'd1);
        key_raw[2] = 1'b1;
        step(20);
        chk("t5_restart_held", 32'(key_held), 32'h01);

        // 6: reset mid-debounce of left, restart held beforehand
        clear_counts();
        key_raw[1] = 1'b0;
        step(8);
        rst = 1'b1;
        #1;
        chk("t6_rst_pulses", 32'(pulses()), 32'h0);
        chk("t6_rst_held", 32'(key_held), 32'h0);
        key_raw[0] = 1'b1;
        step(2);
        rst = 1'b0;
        step(10);
        chk("t6_left_early", 32'(LeftDown), 32'h0);
        step(1);
        chk("t6_left_pulse", 32'(LeftDown), 32'h1);
        chk("t6_held", 32'(key_held), 32'h02);
        step(5);
        chk("t6_left_count", 32'(l_cnt), 32'd1);
        chk("t6_restart_count", 32'(rs_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
